// File: rtl/auth_msg_ingress_if.sv
// ----------------------------------------------------------------------------
// auth_msg_ingress_if
// Handshake bundle between the ingress stage and the authentication core.
//   core_msg_valid/data/src  : FIFO head offered to the core
//   core_msg_ready           : core accepts the head (pop)
//   core_req_valid/slot/code/src : one pending request offered to the core
//   core_req_ready           : core accepts the request
// The master modport is the ingress side, the slave modport is the core side.
// ----------------------------------------------------------------------------
interface auth_msg_ingress_if #(
    parameter int MSG_W = 2048
);
    logic             core_msg_valid;
    logic [MSG_W-1:0] core_msg_data;
    logic             core_msg_src;
    logic             core_msg_ready;
    logic             core_req_valid;
    logic [1:0]       core_req_slot;
    logic [1:0]       core_req_code;
    logic             core_req_src;
    logic             core_req_ready;

    modport master (
        output core_msg_valid, core_msg_data, core_msg_src,
        input  core_msg_ready,
        output core_req_valid, core_req_slot, core_req_code, core_req_src,
        input  core_req_ready
    );

    modport slave (
        input  core_msg_valid, core_msg_data, core_msg_src,
        output core_msg_ready,
        input  core_req_valid, core_req_slot, core_req_code, core_req_src,
        output core_req_ready
    );
endinterface

// File: rtl/auth_msg_ingress.sv
// ----------------------------------------------------------------------------
// auth_msg_ingress
// Ingress stage in front of the authentication controller core. Captures
// messages from the PD and DEBUG drivers on the rising edge of their ready
// levels, arbitrates round-robin on simultaneous edges, buffers them in a
// 2-entry FIFO and acknowledges each capture for one cycle. Separately scans
// both pending-request vectors and offers one request at a time to the core,
// followed by an erase pulse to the originating source.
//
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   PD_msg_ready, DEBUG_msg_ready : driver ready levels (edge = new message)
//   auth_msg_in                 : shared message bus
//   pending_auth_request_PD/DEBUG : four 2-bit slot codes each, slot0 = [1:0]
//   core_if (master)            : message and request handshakes to the core
//   Ack_PD, Ack_DEBUG           : one-cycle capture acknowledges
//   pending_auth_request_*_erase : one-cycle erase pulses
//   overflow                    : sticky, message dropped on a full FIFO
//   hdr_err_cnt                 : saturating header-reject count (macro only)
//
// Optional feature macro: AUTH_INGRESS_HDR_CHECK_EN
//   Defined  : messages with header byte 8'h00 are acked but not buffered,
//              and counted on hdr_err_cnt.
//   Undefined: every message is buffered; hdr_err_cnt does not exist.
// ----------------------------------------------------------------------------
module auth_msg_ingress #(
    parameter int MSG_W      = 2048,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PD_msg_ready,
    input  logic             DEBUG_msg_ready,
    input  logic [MSG_W-1:0] auth_msg_in,
    input  logic [7:0]       pending_auth_request_PD,
    input  logic [7:0]       pending_auth_request_DEBUG,
    auth_msg_ingress_if.master core_if,
    output logic             Ack_PD,
    output logic             Ack_DEBUG,
    output logic             pending_auth_request_PD_erase,
    output logic             pending_auth_request_DEBUG_erase,
    output logic             overflow
`ifdef AUTH_INGRESS_HDR_CHECK_EN
    ,
    output logic [7:0]       hdr_err_cnt
`endif
);

    localparam logic [1:0] LP_FULL = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_ERASE
    } req_state_t;

    // ------------------------------------------------------------------
    // Message capture and arbitration
    // ------------------------------------------------------------------
    logic             r_pd_rdy_q;
    logic             r_dbg_rdy_q;
    logic             r_pd_pend;
    logic             r_dbg_pend;
    logic             r_rr_dbg;      // 1: DEBUG wins the next contention
    logic             r_ack_pd;
    logic             r_ack_dbg;
    logic             r_overflow;

    logic [MSG_W-1:0] r_mem [2];
    logic             r_src [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_pd_req;
    logic             w_dbg_req;
    logic             w_both;
    logic             w_grant_pd;
    logic             w_grant_dbg;
    logic             w_any_grant;
    logic             w_valid;
    logic             w_pop;
    logic             w_full;
    logic             w_hdr_bad;
    logic             w_drop;
    logic             w_push;

    // A pending (previously lost) edge is served exactly like a fresh edge.
    assign w_pd_req    = (PD_msg_ready & ~r_pd_rdy_q) | r_pd_pend;
    assign w_dbg_req   = (DEBUG_msg_ready & ~r_dbg_rdy_q) | r_dbg_pend;
    assign w_both      = w_pd_req & w_dbg_req;
    assign w_grant_pd  = w_pd_req & (~w_dbg_req | ~r_rr_dbg);
    assign w_grant_dbg = w_dbg_req & ~w_grant_pd;
    assign w_any_grant = w_grant_pd | w_grant_dbg;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & core_if.core_msg_ready;
    assign w_full  = (r_count == LP_FULL);

`ifdef AUTH_INGRESS_HDR_CHECK_EN
    assign w_hdr_bad = (auth_msg_in[MSG_W-1 -: 8] == 8'h00);
`else
    assign w_hdr_bad = 1'b0;
`endif

    // A rejected header never needs FIFO space, so it cannot overflow.
    // A pop in the same cycle frees the slot the capture needs.
    assign w_drop = w_any_grant & ~w_hdr_bad & w_full & ~w_pop;
    assign w_push = w_any_grant & ~w_hdr_bad & ~w_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pd_rdy_q  <= 1'b0;
            r_dbg_rdy_q <= 1'b0;
            r_pd_pend   <= 1'b0;
            r_dbg_pend  <= 1'b0;
            r_rr_dbg    <= 1'b0;
            r_ack_pd    <= 1'b0;
            r_ack_dbg   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_pd_rdy_q  <= PD_msg_ready;
            r_dbg_rdy_q <= DEBUG_msg_ready;
            r_pd_pend   <= w_pd_req & ~w_grant_pd;
            r_dbg_pend  <= w_dbg_req & ~w_grant_dbg;
            // Only a real contention moves the round-robin pointer, so a
            // held-over loser served alone does not steal the next turn.
            if (w_both) begin
                r_rr_dbg <= w_grant_pd;
            end
            r_ack_pd  <= w_grant_pd & ~w_drop;
            r_ack_dbg <= w_grant_dbg & ~w_drop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Pointer-indexed write; on a full FIFO with a pop the write lands in the
    // slot being vacated, which becomes the tail behind the new head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
                r_src[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= auth_msg_in;
                r_src[r_wr_ptr] <= w_grant_dbg;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AUTH_INGRESS_HDR_CHECK_EN
    logic [7:0] r_hdr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hdr_cnt <= 8'h00;
        end else if (w_any_grant && w_hdr_bad && (r_hdr_cnt != 8'hFF)) begin
            r_hdr_cnt <= r_hdr_cnt + 8'h01;
        end
    end

    assign hdr_err_cnt = r_hdr_cnt;
`endif

    assign core_if.core_msg_valid = w_valid;
    assign core_if.core_msg_data  = r_mem[r_rd_ptr];
    assign core_if.core_msg_src   = r_src[r_rd_ptr];
    assign Ack_PD                 = r_ack_pd;
    assign Ack_DEBUG              = r_ack_dbg;
    assign overflow               = r_overflow;

    // ------------------------------------------------------------------
    // Pending-request scanner and offer FSM
    // ------------------------------------------------------------------
    req_state_t r_state;
    req_state_t w_state_nxt;
    logic       r_req_pri_dbg;   // 1: DEBUG scanned first
    logic [1:0] r_req_slot;
    logic [1:0] r_req_code;
    logic       r_req_src;

    logic       w_pd_hit;
    logic [1:0] w_pd_slot;
    logic [1:0] w_pd_code;
    logic       w_dbg_hit;
    logic [1:0] w_dbg_slot;
    logic [1:0] w_dbg_code;
    logic       w_pick_dbg;
    logic       w_scan_hit;

    // Lowest non-zero slot per source.
    always_comb begin
        w_pd_hit   = 1'b0;
        w_pd_slot  = 2'd0;
        w_pd_code  = 2'd0;
        w_dbg_hit  = 1'b0;
        w_dbg_slot = 2'd0;
        w_dbg_code = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_pd_hit && (pending_auth_request_PD[2*i +: 2] != 2'b00)) begin
                w_pd_hit  = 1'b1;
                w_pd_slot = 2'(i);
                w_pd_code = pending_auth_request_PD[2*i +: 2];
            end
            if (!w_dbg_hit && (pending_auth_request_DEBUG[2*i +: 2] != 2'b00)) begin
                w_dbg_hit  = 1'b1;
                w_dbg_slot = 2'(i);
                w_dbg_code = pending_auth_request_DEBUG[2*i +: 2];
            end
        end
    end

    assign w_pick_dbg = w_dbg_hit & (~w_pd_hit | r_req_pri_dbg);
    assign w_scan_hit = w_pd_hit | w_dbg_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_scan_hit) w_state_nxt = ST_OFFER;
            ST_OFFER: if (core_if.core_req_ready) w_state_nxt = ST_ERASE;
            ST_ERASE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        core_if.core_req_valid           = (r_state == ST_OFFER);
        pending_auth_request_PD_erase    = (r_state == ST_ERASE) & ~r_req_src;
        pending_auth_request_DEBUG_erase = (r_state == ST_ERASE) & r_req_src;
    end

    // The latched request is frozen outside IDLE, so vector changes during
    // OFFER/ERASE cannot disturb the offer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_pri_dbg <= 1'b0;
            r_req_slot    <= 2'd0;
            r_req_code    <= 2'd0;
            r_req_src     <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_scan_hit) begin
            r_req_slot    <= w_pick_dbg ? w_dbg_slot : w_pd_slot;
            r_req_code    <= w_pick_dbg ? w_dbg_code : w_pd_code;
            r_req_src     <= w_pick_dbg;
            r_req_pri_dbg <= ~w_pick_dbg;
        end
    end

    assign core_if.core_req_slot = r_req_slot;
    assign core_if.core_req_code = r_req_code;
    assign core_if.core_req_src  = r_req_src;

endmodule

// File: doc/auth_msg_ingress.md
Name: auth_msg_ingress

Overview:
- Ingress stage sitting directly upstream of the authentication controller core.
- Accepts authentication messages from the PD and DEBUG drivers, arbitrates between them, and buffers them in a 2-entry FIFO.
- Presents buffered messages to the core over a valid/ready handshake and returns a one-cycle acknowledge to the originating driver.
- Also scans both pending-request vectors and forwards one request at a time to the core, then issues the matching erase pulse.

Parameters:
MSG_W, 2048, message width in bits; set from `MSG_LEN at instantiation.
FIFO_DEPTH, 2, buffer entries; only 2 is supported (1-bit pointers plus a count).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
PD_msg_ready  in  1  PD driver has a message on auth_msg_in (level)
DEBUG_msg_ready  in  1  DEBUG driver has a message on auth_msg_in (level)
auth_msg_in  in  MSG_W  shared message bus from the drivers
pending_auth_request_PD  in  8  four 2-bit slot request codes, slot0 = [1:0]; 00 = none
pending_auth_request_DEBUG  in  8  same format, DEBUG source
core_msg_valid  out  1  FIFO head valid
core_msg_data  out  MSG_W  FIFO head message
core_msg_src  out  1  0 = PD, 1 = DEBUG
core_msg_ready  in  1  core accepts the head
core_req_valid  out  1  pending request offered
core_req_slot  out  2  slot index
core_req_code  out  2  request code
core_req_src  out  1  0 = PD, 1 = DEBUG
core_req_ready  in  1  core accepts the request
Ack_PD  out  1  one-cycle capture acknowledge to PD
Ack_DEBUG  out  1  one-cycle capture acknowledge to DEBUG
pending_auth_request_PD_erase  out  1  one-cycle erase pulse
pending_auth_request_DEBUG_erase  out  1  one-cycle erase pulse
overflow  out  1  sticky; set when a message is dropped on a full FIFO

Behaviour:
Reset:
- All outputs are 0, the FIFO is empty, and the round-robin pointer favours PD.
- Reset mid-transfer discards all buffered messages and any pending ack.

Message capture:
- A message is detected on the rising edge of PD_msg_ready or DEBUG_msg_ready; each ready is registered for edge detection.
- If both sources rise in the same cycle, the source that did not win last time is granted. The loser's edge is held pending and captured in a later cycle.
- Capture writes auth_msg_in into the FIFO in the cycle the edge is seen.
- Ack_<src> pulses high for exactly 1 cycle, in the cycle after capture.
- If the FIFO is full at the edge: the message is dropped, no ack is issued, and overflow is set. overflow clears only on reset.
- A simultaneous capture and core pop on a full FIFO is allowed: count stays 2 and nothing is dropped.

Core message handshake:
- core_msg_valid = (count != 0). core_msg_data and core_msg_src are driven from registers at the FIFO head.
- A pop occurs when core_msg_valid && core_msg_ready; the next entry becomes visible the following cycle.
- Head data stays stable while valid is high and ready is low.

Request FSM (states IDLE, OFFER, ERASE):
- IDLE: scan PD then DEBUG, alternating priority after each grant. Within a source, pick the lowest slot whose code != 00. On a hit, latch slot, code and src, then go to OFFER.
- OFFER: core_req_valid = 1. When core_req_ready is seen, go to ERASE.
- ERASE: pulse the matching *_erase for 1 cycle, then return to IDLE.
- While in OFFER or ERASE, changes to the pending vectors are ignored.
- The earliest offer is 1 cycle after the code is visible.

Width rules:
- FIFO pointers wrap modulo 2.
- The count saturates conceptually and never exceeds 2; reaching 2 means full.

Optional Feature:
AUTH_INGRESS_HDR_CHECK_EN
- Defined: a captured message whose header byte auth_msg_in[MSG_W-1:MSG_W-8] == 8'h00 is rejected. It is not written to the FIFO, is still acknowledged, and increments an 8-bit saturating hdr_err_cnt output port; the port exists only when the macro is defined.
- Undefined: every message is buffered and the port is absent.

Test Plan:
1. Release reset, raise PD_msg_ready with header 8'h11 -> Ack_PD high for 1 cycle, 1 cycle after capture; core_msg_valid=1, core_msg_src=0, data matches.
2. Raise PD and DEBUG ready in the same cycle -> PD captured first, DEBUG the next cycle. Repeat the simultaneous raise -> DEBUG is now captured first.
3. Hold core_msg_ready=0 and send 3 messages -> the first 2 are acked and buffered, the 3rd gets no ack and overflow=1. Then pop twice -> messages come out in FIFO order.
4. pending_auth_request_PD=8'b10_01_00_11 with core_req_ready delayed 3 cycles -> slot=0, code=11, src=0 held stable; pending_auth_request_PD_erase pulses once the cycle after acceptance.
5. Assert reset low mid-OFFER with the FIFO holding 1 entry -> all outputs 0 immediately; after release, core_msg_valid=0.
6. With AUTH_INGRESS_HDR_CHECK_EN defined, send header 8'h00 -> ack issued, core_msg_valid stays 0, hdr_err_cnt=1.
